apb_master_bridge: RTL

- Upstream neighbour of the APB slave memory. Converts a simple valid/ready request stream into APB setup/access transfers on the shared APB interface signals.
- Buffers requests in a small command FIFO.
- Returns one response per transfer (read data, direction, error) on a valid/ready response channel.
- Flags a transfer as errored when the slave holds pready low too long.

---
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: buffers valid/ready requests in a small FIFO and
// issues APB setup/access transfers, returning one response per transfer.
module apb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       pclk,
    input  logic                       prst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [AW-1:0]              req_addr,
    input  logic                       req_write,
    input  logic [DW-1:0]              req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_write,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [AW-1:0]              paddr,
    output logic                       pwrite,
    output logic [DW-1:0]              pwdata,
    output logic                       psel,
    output logic                       penable,
    input  logic [DW-1:0]              prdata,
    input  logic                       pready
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT-1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state_q, state_d;

    logic [AW-1:0] fa_q [DEPTH];
    logic          fw_q [DEPTH];
    logic [DW-1:0] fd_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;

    logic [AW-1:0] paddr_q;
    logic          pwrite_q;
    logic [DW-1:0] pwdata_q;
    logic [DW-1:0] rdata_q;
    logic          rwrite_q;
    logic          rerr_q;
    logic [CW-1:0] cnt_q;

    logic full, empty, push, pop, tmo, done;

    assign full      = (count_q == LW'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full && !prst;
    assign push      = req_valid && req_ready;
    assign tmo       = (cnt_q == TMAX);
    assign done      = (state_q == ACCESS) && (pready || tmo);

    // FIFO storage; entries need no reset because count_q guards them
    always_ff @(posedge pclk) begin
        if (push) begin
            fa_q[wr_ptr_q] <= req_addr;
            fw_q[wr_ptr_q] <= req_write;
            fd_q[wr_ptr_q] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap since DEPTH is 2^n
    always_ff @(posedge pclk) begin
        if (prst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + LW'(1);
            else if (!push && pop) count_q <= count_q - LW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge pclk) begin
        if (prst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (!empty) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: if (pready || tmo) state_d = RESP;
            RESP:   if (rsp_ready) state_d = empty ? IDLE : SETUP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; a pop always coincides with entry to SETUP
    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE:   pop = !empty;
            SETUP:  psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                pop       = rsp_ready && !empty;
            end
            default: ;
        endcase
    end

    // APB command, wait counter and response capture
    always_ff @(posedge pclk) begin
        if (prst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            rwrite_q <= 1'b0;
            rerr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (pop) begin
                paddr_q  <= fa_q[rd_ptr_q];
                pwrite_q <= fw_q[rd_ptr_q];
                pwdata_q <= fd_q[rd_ptr_q];
                cnt_q    <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done) begin
                rdata_q  <= (pready && !pwrite_q) ? prdata : '0;
                rwrite_q <= pwrite_q;
                rerr_q   <= !pready;
            end
        end
    end

    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_write  = rwrite_q;
    assign rsp_err    = rerr_q;
    assign fifo_level = count_q;

endmodule
